// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data SRAM responder: MMIO map, request payload, helpers.
package data_sram_responder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned OFF_W  = 16;
  localparam int unsigned LED_W  = 16;
  localparam int unsigned SW_W   = 8;

  localparam logic [DATA_W-1:0] DEFAULT_MMIO_BASE = 32'hbfaf_0000;

  localparam logic [OFF_W-1:0] LED_OFF       = 16'hf000;
  localparam logic [OFF_W-1:0] SWITCH_OFF    = 16'hf004;
  localparam logic [OFF_W-1:0] TIMER_OFF     = 16'hf008;
  localparam logic [OFF_W-1:0] SCRATCH_OFF   = 16'hf00c;
  localparam logic [OFF_W-1:0] STORE_CNT_OFF = 16'hf010;

  // Register-window request as seen by the MMIO block
  typedef struct packed {
    logic [OFF_W-1:0]  off;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } mmio_req_t;

  // Only the upper halfword of the address selects the register window
  function automatic logic sel_mmio(input logic [15:0] addr_hi, input logic [15:0] base_hi);
    return addr_hi == base_hi;
  endfunction

  // Replace the byte lanes of old_w enabled in be with those of new_w
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_mmio_regs.sv
// Memory-mapped register window: LED, synchronised switches, timer, scratch, store counter.
// The timer exists only when DATA_SRAM_TIMER_EN is defined; otherwise its offset reads 0.
module data_sram_mmio_regs
  import data_sram_responder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_store,
  input  logic              i_mmio_wr,
  input  mmio_req_t         i_req,
  input  logic [SW_W-1:0]   i_switch,
  output logic [LED_W-1:0]  o_led,
  output logic [DATA_W-1:0] o_rdata_c
);

  logic [LED_W-1:0]  r_led;
  logic [SW_W-1:0]   r_sw_meta;
  logic [SW_W-1:0]   r_sw_sync;
  logic [DATA_W-1:0] r_scratch;
  logic [DATA_W-1:0] r_store_cnt;
  logic              w_led_wr;
  logic              w_scratch_wr;

  // Per-register write strobes
  always_comb begin
    w_led_wr     = i_mmio_wr && (i_req.off == LED_OFF);
    w_scratch_wr = i_mmio_wr && (i_req.off == SCRATCH_OFF);
  end

  // LED register, byte lanes 0 and 1 only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led <= '0;
    end else if (w_led_wr) begin
      if (i_req.be[0]) r_led[7:0]  <= i_req.wdata[7:0];
      if (i_req.be[1]) r_led[15:8] <= i_req.wdata[15:8];
    end
  end

  // Two-flop synchroniser for the asynchronous switch inputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= i_switch;
      r_sw_sync <= r_sw_meta;
    end
  end

  // Scratch register with byte enables
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scratch <= '0;
    end else if (w_scratch_wr) begin
      r_scratch <= merge_bytes(r_scratch, i_req.wdata, i_req.be);
    end
  end

  // Counts every store request, RAM or MMIO, mapped or not
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_store_cnt <= '0;
    end else if (i_store) begin
      r_store_cnt <= r_store_cnt + 32'd1;
    end
  end

`ifdef DATA_SRAM_TIMER_EN
  logic [DATA_W-1:0] r_timer;
  logic              w_timer_wr;

  // Timer write strobe
  always_comb begin
    w_timer_wr = i_mmio_wr && (i_req.off == TIMER_OFF);
  end

  // Free-running timer; a write loads merged bytes instead of incrementing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_timer_wr) begin
      r_timer <= merge_bytes(r_timer, i_req.wdata, i_req.be);
    end else begin
      r_timer <= r_timer + 32'd1;
    end
  end
`endif

  // Read mux over the current (pre-edge) register values
  always_comb begin
    o_rdata_c = '0;
    case (i_req.off)
      LED_OFF:       o_rdata_c = {16'h0000, r_led};
      SWITCH_OFF:    o_rdata_c = {24'h00_0000, r_sw_sync};
`ifdef DATA_SRAM_TIMER_EN
      TIMER_OFF:     o_rdata_c = r_timer;
`endif
      SCRATCH_OFF:   o_rdata_c = r_scratch;
      STORE_CNT_OFF: o_rdata_c = r_store_cnt;
      default:       o_rdata_c = '0;
    endcase
  end

  assign o_led = r_led;

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM port responder: word RAM plus MMIO window, 1-cycle registered read data.
// Optional macro DATA_SRAM_TIMER_EN enables the free-running timer register.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 12,
  parameter logic [DATA_W-1:0] MMIO_BASE = DEFAULT_MMIO_BASE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_sram_en,
  input  logic [BE_W-1:0]   data_sram_we,
  input  logic [31:0]       data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic [LED_W-1:0]  led,
  input  logic [SW_W-1:0]   switch
);

  localparam int unsigned RAM_DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [RAM_DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              w_is_mmio;
  logic              w_store;
  logic              w_load;
  logic              w_ram_wr;
  logic              w_mmio_wr;
  logic [ADDR_W-1:0] w_idx;
  mmio_req_t         w_req;
  logic [DATA_W-1:0] w_mmio_rdata;

  // Region decode and request classification
  always_comb begin
    w_is_mmio   = sel_mmio(data_sram_addr[31:16], MMIO_BASE[31:16]);
    w_store     = data_sram_en && (data_sram_we != 4'b0000);
    w_load      = data_sram_en && (data_sram_we == 4'b0000);
    w_ram_wr    = w_store && !w_is_mmio && !reset;
    w_mmio_wr   = w_store && w_is_mmio;
    w_idx       = data_sram_addr[ADDR_W+1:2];
    w_req.off   = data_sram_addr[15:0];
    w_req.be    = data_sram_we;
    w_req.wdata = data_sram_wdata;
  end

  data_sram_mmio_regs u_mmio_regs (
    .clk       (clk),
    .reset     (reset),
    .i_store   (w_store),
    .i_mmio_wr (w_mmio_wr),
    .i_req     (w_req),
    .i_switch  (switch),
    .o_led     (led),
    .o_rdata_c (w_mmio_rdata)
  );

  // RAM byte-lane writes; contents are deliberately not reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(BE_W); i++) begin
      if (w_ram_wr && data_sram_we[i]) r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
    end
  end

  // Read data register: loads on a read, otherwise holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (w_load) begin
      r_rdata <= w_is_mmio ? w_mmio_rdata : r_mem[w_idx];
    end
  end

  assign data_sram_rdata = r_rdata;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: directed vector table, hand sequences
// for switch sync and mid-stream reset, then random traffic against a behavioural model.
module tb_data_sram_responder;

`ifdef DATA_SRAM_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] led;
  logic [7:0]  switch;

  data_sram_responder dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .led             (led),
    .switch          (switch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Behavioural model state
  bit [31:0] m_mem [int];
  bit [31:0] m_rdata;
  bit [15:0] m_led;
  bit [31:0] m_scratch;
  bit [31:0] m_cnt;
  bit [31:0] m_tval;
  longint    m_tedge;
  longint    m_rel;
  longint    edge_n = 0;
  bit [7:0]  sw_hist [longint];

  function automatic bit [31:0] mask_of(input bit [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic bit [31:0] merge(input bit [31:0] o, input bit [31:0] n, input bit [3:0] be);
    return (o & ~mask_of(be)) | (n & mask_of(be));
  endfunction

  // Timer value during the cycle that ends with edge k
  function automatic bit [31:0] timer_at(input longint k);
    return m_tval + 32'(k - 1 - m_tedge);
  endfunction

  // Switch value seen by a read at edge k: sampled two edges earlier, 0 until the sync has filled
  function automatic bit [31:0] sw_at(input longint k);
    if (k - 2 >= m_rel + 1) return {24'h0, sw_hist[k-2]};
    return 32'h0;
  endfunction

  function automatic bit [31:0] mmio_read(input bit [15:0] off, input longint k);
    case (off)
      16'hf000: return {16'h0, m_led};
      16'hf004: return sw_at(k);
      16'hf008: return TIMER_EN ? timer_at(k) : 32'h0;
      16'hf00c: return m_scratch;
      16'hf010: return m_cnt;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input bit en, input bit [3:0] we, input bit [31:0] addr,
                            input bit [31:0] wd, input longint k);
    bit mm;
    int idx;
    mm  = (addr[31:16] == 16'hbfaf);
    idx = int'(addr[13:2]);
    if (en && we == 4'h0) begin
      m_rdata = mm ? mmio_read(addr[15:0], k) : m_mem[idx];
    end else if (en) begin
      if (mm) begin
        case (addr[15:0])
          16'hf000: m_led = 16'(merge({16'h0, m_led}, wd, we));
          16'hf00c: m_scratch = merge(m_scratch, wd, we);
          16'hf008: if (TIMER_EN) begin
                      m_tval  = merge(timer_at(k), wd, we);
                      m_tedge = k;
                    end
          default: ;
        endcase
      end else begin
        m_mem[idx] = merge(m_mem.exists(idx) ? m_mem[idx] : 32'h0, wd, we);
      end
      m_cnt = m_cnt + 32'd1;
    end
  endtask

  task automatic model_reset();
    m_rdata = 32'h0; m_led = 16'h0; m_scratch = 32'h0; m_cnt = 32'h0; m_tval = 32'h0;
  endtask

  task automatic model_release();
    m_rel   = edge_n;
    m_tedge = edge_n;
    m_tval  = 32'h0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // One clock cycle with a request; model advanced at the edge, outputs checked 1 time unit later
  task automatic step(input logic en, input logic [3:0] we, input logic [31:0] addr,
                      input logic [31:0] wd, input string tag);
    data_sram_en    = en;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wd;
    sw_hist[edge_n+1] = switch;
    @(posedge clk);
    edge_n++;
    model_edge(en, we, addr, wd, edge_n);
    #1;
    chk({tag, "_rdata"}, data_sram_rdata, m_rdata);
    chk({tag, "_led"}, {16'h0, led}, {16'h0, m_led});
  endtask

  function automatic logic [31:0] ram_addr(input int idx);
    logic [31:0] a;
    a = $urandom & 32'h7fff_c003;
    return a | (32'(idx) << 2);
  endfunction

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [15:0] exp_led;
  } vec_t;

  vec_t        tbl [28];
  int          pool [8];
  logic [15:0] offs [7] = '{16'hf000, 16'hf004, 16'hf008, 16'hf00c, 16'hf010, 16'hf014, 16'hf020};

  initial begin
    tbl[0]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,          32'h0000_0000, 16'h0000};
    tbl[1]  = '{1'b1, 4'hf, 32'h0000_0100, 32'h1234_5678, 32'h0000_0000, 16'h0000};
    tbl[2]  = '{1'b1, 4'h0, 32'h0000_0100, 32'h0,          32'h1234_5678, 16'h0000};
    tbl[3]  = '{1'b1, 4'hf, 32'h0000_0200, 32'h1111_1111, 32'h1234_5678, 16'h0000};
    tbl[4]  = '{1'b1, 4'h5, 32'h0000_0200, 32'haabb_ccdd, 32'h1234_5678, 16'h0000};
    tbl[5]  = '{1'b1, 4'h0, 32'h0000_0200, 32'h0,          32'h11bb_11dd, 16'h0000};
    tbl[6]  = '{1'b1, 4'hf, 32'hbfaf_f000, 32'h0000_00ff, 32'h11bb_11dd, 16'h00ff};
    tbl[7]  = '{1'b1, 4'h0, 32'hbfaf_f000, 32'h0,          32'h0000_00ff, 16'h00ff};
    tbl[8]  = '{1'b1, 4'h2, 32'hbfaf_f000, 32'h1234_ab00, 32'h0000_00ff, 16'habff};
    tbl[9]  = '{1'b1, 4'h0, 32'hbfaf_f000, 32'h0,          32'h0000_abff, 16'habff};
    tbl[10] = '{1'b1, 4'hf, 32'hbfaf_f00c, 32'hdead_beef, 32'h0000_abff, 16'habff};
    tbl[11] = '{1'b1, 4'h0, 32'hbfaf_f00c, 32'h0,          32'hdead_beef, 16'habff};
    tbl[12] = '{1'b1, 4'hf, 32'hbfaf_f004, 32'hffff_ffff, 32'hdead_beef, 16'habff};
    tbl[13] = '{1'b1, 4'h0, 32'hbfaf_f004, 32'h0,          32'h0000_0000, 16'habff};
    tbl[14] = '{1'b1, 4'h0, 32'hbfaf_f00c, 32'h0,          32'hdead_beef, 16'habff};
    tbl[15] = '{1'b1, 4'hf, 32'hbfaf_f020, 32'h5555_5555, 32'hdead_beef, 16'habff};
    tbl[16] = '{1'b1, 4'h0, 32'hbfaf_f020, 32'h0,          32'h0000_0000, 16'habff};
    tbl[17] = '{1'b1, 4'h0, 32'hbfaf_f010, 32'h0,          32'h0000_0008, 16'habff};
    tbl[18] = '{1'b1, 4'hf, 32'hbfaf_f008, 32'hffff_fffe, 32'h0000_0008, 16'habff};
    tbl[19] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,          32'h0000_0008, 16'habff};
    tbl[20] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,          32'h0000_0008, 16'habff};
    tbl[21] = '{1'b1, 4'h0, 32'hbfaf_f008, 32'h0,          32'h0000_0000, 16'habff};
    tbl[22] = '{1'b1, 4'h0, 32'hbfaf_f008, 32'h0,          TIMER_EN ? 32'h1 : 32'h0, 16'habff};
    tbl[23] = '{1'b1, 4'h1, 32'hbfaf_f008, 32'h0000_0077, TIMER_EN ? 32'h1 : 32'h0, 16'habff};
    tbl[24] = '{1'b1, 4'h0, 32'hbfaf_f008, 32'h0,          TIMER_EN ? 32'h77 : 32'h0, 16'habff};
    tbl[25] = '{1'b1, 4'h0, 32'hbfaf_f010, 32'h0,          32'h0000_000a, 16'habff};
    tbl[26] = '{1'b1, 4'h0, 32'h0000_4100, 32'h0,          32'h1234_5678, 16'habff};
    tbl[27] = '{1'b1, 4'h0, 32'h0000_0202, 32'h0,          32'h11bb_11dd, 16'habff};

    reset = 1'b1;
    data_sram_en = 1'b0; data_sram_we = 4'h0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
    switch = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    chk("por_rdata", data_sram_rdata, 32'h0);
    chk("por_led", {16'h0, led}, 32'h0);
    reset = 1'b0;
    model_release();

    // Directed vectors
    for (int i = 0; i < 28; i++) begin
      step(tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].wd, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_tbl_rdata", i), data_sram_rdata, tbl[i].exp_rd);
      chk($sformatf("vec%0d_tbl_led", i), {16'h0, led}, {16'h0, tbl[i].exp_led});
    end

    // Switch through the two-flop synchroniser
    switch = 8'h5a;
    step(1'b0, 4'h0, 32'h0, 32'h0, "sw_idle");
    step(1'b1, 4'h0, 32'hbfaf_f004, 32'h0, "sw_early");
    chk("sw_early_const", data_sram_rdata, 32'h0);
    step(1'b1, 4'h0, 32'hbfaf_f004, 32'h0, "sw_ready");
    chk("sw_ready_const", data_sram_rdata, 32'h0000_005a);

    // Mid-stream asynchronous reset
    step(1'b1, 4'hf, 32'hbfaf_f000, 32'h0000_1234, "pre_rst_led");
    step(1'b1, 4'h0, 32'hbfaf_f000, 32'h0, "pre_rst_rd");
    data_sram_en = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_rdata", data_sram_rdata, 32'h0);
    chk("rst_led", {16'h0, led}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_release();
    step(1'b1, 4'h0, 32'hbfaf_f004, 32'h0, "post_rst_sw");
    step(1'b1, 4'h0, 32'hbfaf_f010, 32'h0, "post_rst_cnt");
    chk("post_rst_cnt_const", data_sram_rdata, 32'h0);
    step(1'b1, 4'h0, 32'h0000_0100, 32'h0, "post_rst_ram");
    chk("post_rst_ram_const", data_sram_rdata, 32'h1234_5678);
    step(1'b1, 4'h0, 32'hbfaf_f008, 32'h0, "post_rst_tmr");

    // Random traffic against the model
    for (int i = 0; i < 8; i++) begin
      pool[i] = int'($urandom_range(0, 4095));
      step(1'b1, 4'hf, ram_addr(pool[i]), $urandom, $sformatf("pre%0d", i));
    end
    for (int i = 0; i < 400; i++) begin
      logic        en;
      logic [3:0]  we;
      logic [31:0] addr;
      if ($urandom_range(0, 7) == 0) switch = 8'($urandom);
      en   = ($urandom_range(0, 5) != 0);
      we   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      addr = ($urandom_range(0, 9) < 4) ? {16'hbfaf, offs[$urandom_range(0, 6)]}
                                        : ram_addr(pool[$urandom_range(0, 7)]);
      step(en, we, addr, $urandom, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
